pll_lock_supervisor: RTL and testbench

Reset/lock sequencer that sits on the consumer side of a PLL wrapper's RST/LOCK interface in the CrossLink camera path. It drives the PLL reset pulse and watches the asynchronous LOCK output. It holds the downstream system reset until lock has been stable, and re-locks automatically on lock loss. Runs on the PLL reference clock (CLKI) because the PLL outputs are not trustworthy until lock.

---
 rtl/pll_lock_supervisor_if.sv | 60 ++++++
 rtl/pll_lock_supervisor.sv | 210 +++++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_supervisor_if.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor_if
//
// Signal bundle between the PLL lock supervisor and its environment (the PLL
// wrapper's RST/LOCK pins plus the downstream reset/status consumers).
//
// Signals:
//   LOCK       PLL lock, asynchronous to CLKI (into supervisor)
//   RESTART    synchronous pulse forcing a fresh lock sequence (into supervisor)
//   PLL_RST    active-high reset to the PLL (from supervisor)
//   SYS_RST    active-high downstream system reset (from supervisor)
//   READY      high only while the supervisor is in RUN
//   FAULT      high only while the supervisor is in FAULT
//   RETRY_CNT  failed lock attempts in the current sequence
//   LOSS_CNT   lock-loss events seen in RUN (zero unless the counter is built)
//   state_dbg  current FSM state encoding, for checkers and debug
//
// Handshake semantics: there is no valid/ready transfer on this bundle. Every
// signal is level-sensitive and sampled every CLKI cycle; RESTART acts for as
// long as it is high, and all supervisor outputs are registered.
//
// Modports:
//   master  the supervisor itself
//   slave   the PLL wrapper / downstream consumer side
// ---------------------------------------------------------------------------
interface pll_lock_supervisor_if;
  logic       LOCK;
  logic       RESTART;
  logic       PLL_RST;
  logic       SYS_RST;
  logic       READY;
  logic       FAULT;
  logic [7:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;
  logic [2:0] state_dbg;

  modport master (
    input  LOCK,
    input  RESTART,
    output PLL_RST,
    output SYS_RST,
    output READY,
    output FAULT,
    output RETRY_CNT,
    output LOSS_CNT,
    output state_dbg
  );

  modport slave (
    output LOCK,
    output RESTART,
    input  PLL_RST,
    input  SYS_RST,
    input  READY,
    input  FAULT,
    input  RETRY_CNT,
    input  LOSS_CNT,
    input  state_dbg
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Reset/lock sequencer on the consumer side of a PLL wrapper. It pulses the
// PLL reset, waits for the (asynchronous) LOCK output, requires lock to stay
// up for a number of cycles before releasing the downstream reset, and goes
// back through a PLL reset whenever lock is lost. Repeated failures to lock
// end in a sticky FAULT state that only RST or RESTART can leave. Everything
// runs on CLKI, the PLL reference clock, because the PLL outputs cannot be
// trusted before lock.
//
// Ports:
//   CLKI  reference clock (also the PLL input clock)
//   RST   asynchronous, active-high reset
//   bus   pll_lock_supervisor_if.master (LOCK, RESTART in; PLL_RST, SYS_RST,
//         READY, FAULT, RETRY_CNT, LOSS_CNT, state_dbg out)
//
// Parameters:
//   RST_PULSE_CYCLES     CLKI cycles PLL_RST is held per attempt (>=1)
//   LOCK_TIMEOUT_CYCLES  CLKI cycles to wait for lock before retrying (>=2)
//   LOCK_STABLE_CYCLES   consecutive synchronized-lock cycles before release
//   MAX_RETRIES          failed attempts tolerated before FAULT (1..255)
//   CNT_W                width of the shared cycle counter
//
// Build option:
//   PLL_SUP_LOSS_COUNT_EN  when defined, LOSS_CNT counts RUN lock-loss events
//                          (saturating at 255, cleared only by RST); when
//                          undefined, LOSS_CNT is tied to zero.
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 16
) (
  input  logic                   CLKI,
  input  logic                   RST,
  pll_lock_supervisor_if.master  bus
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  // Terminal counts for the shared counter; each phase ends on its last cycle.
  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [8:0]       MAX_RETRY_W = 9'(MAX_RETRIES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pll_rst_q;
  logic             sys_rst_q;
  logic             ready_q;
  logic             fault_q;
  logic [7:0]       retry_cnt_q;

  // Two-flop synchronizer for the asynchronous LOCK input.
  logic lock_meta;
  logic lock_s;

  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.LOCK;
      lock_s    <= lock_meta;
    end
  end

  // Retry budget check uses one extra bit so RETRY_CNT+1 cannot wrap.
  logic retries_exhausted;
  assign retries_exhausted = ({1'b0, retry_cnt_q} + 9'd1) >= MAX_RETRY_W;

`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q;
`endif

  // Main sequencer. Outputs are registered alongside the state so that each
  // output changes on the same edge as the state it belongs to.
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      state       <= S_RESET_PLL;
      cnt         <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_cnt_q <= 8'd0;
`ifdef PLL_SUP_LOSS_COUNT_EN
      loss_cnt_q  <= 8'd0;
`endif
    end else if (bus.RESTART) begin
      // RESTART overrides every lock/timeout event in the same cycle, and
      // holding it high simply parks the block at the start of RESET_PLL.
      state       <= S_RESET_PLL;
      cnt         <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      retry_cnt_q <= 8'd0;
    end else begin
      unique case (state)
        S_RESET_PLL: begin
          if (cnt == RST_TC) begin
            state     <= S_WAIT_LOCK;
            cnt       <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_WAIT_LOCK: begin
          if (lock_s) begin
            state <= S_STABILIZE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_TC) begin
            // A timeout always counts as a failed attempt; the budget decides
            // whether we try again or give up.
            retry_cnt_q <= retry_cnt_q + 8'd1;
            cnt         <= '0;
            pll_rst_q   <= 1'b1;
            if (retries_exhausted) begin
              state   <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              state <= S_RESET_PLL;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_STABILIZE: begin
          if (!lock_s) begin
            // Lock chattered: start a fresh timeout window without pulsing
            // the PLL reset again.
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_TC) begin
            state       <= S_RUN;
            cnt         <= '0;
            sys_rst_q   <= 1'b0;
            ready_q     <= 1'b1;
            retry_cnt_q <= 8'd0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_RUN: begin
          if (!lock_s) begin
            state     <= S_RESET_PLL;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
`ifdef PLL_SUP_LOSS_COUNT_EN
            if (loss_cnt_q != 8'hFF) begin
              loss_cnt_q <= loss_cnt_q + 8'd1;
            end
`endif
          end
        end

        S_FAULT: begin
          // Sticky: keep the PLL and the system in reset until RST/RESTART.
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
          fault_q   <= 1'b1;
          cnt       <= '0;
        end

        default: begin
          state     <= S_RESET_PLL;
          cnt       <= '0;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
          fault_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PLL_RST   = pll_rst_q;
  assign bus.SYS_RST   = sys_rst_q;
  assign bus.READY     = ready_q;
  assign bus.FAULT     = fault_q;
  assign bus.RETRY_CNT = retry_cnt_q;
  assign bus.state_dbg = state;

`ifdef PLL_SUP_LOSS_COUNT_EN
  assign bus.LOSS_CNT = loss_cnt_q;
`else
  assign bus.LOSS_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with RST_PULSE_CYCLES=4,
// LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2. Inputs are
// driven and outputs sampled 1 time unit after a rising CLKI edge; the cycle
// counts in the comments refer to rising edges after the input change.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  logic CLKI;
  logic RST;

  int checks;
  int errors;

`ifdef PLL_SUP_LOSS_COUNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic [7:0] loss_exp;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2),
    .CNT_W               (16)
  ) dut (
    .CLKI (CLKI),
    .RST  (RST),
    .bus  (bus.master)
  );

  // Clock / reset block
  initial CLKI = 1'b0;
  always #5 CLKI = ~CLKI;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLKI);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loss counter expectation only moves when the counter is built.
  task automatic note_loss();
    if (LOSS_EN && loss_exp != 8'hFF) loss_exp = loss_exp + 8'd1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    loss_exp = 8'd0;

    RST         = 1'b1;
    bus.LOCK    = 1'b0;
    bus.RESTART = 1'b0;
    step(2);

    // Reset state
    chk("rst_pll_rst",  32'(bus.PLL_RST),   32'd1);
    chk("rst_sys_rst",  32'(bus.SYS_RST),   32'd1);
    chk("rst_ready",    32'(bus.READY),     32'd0);
    chk("rst_fault",    32'(bus.FAULT),     32'd0);
    chk("rst_retry",    32'(bus.RETRY_CNT), 32'd0);
    chk("rst_loss",     32'(bus.LOSS_CNT),  32'd0);
    chk("rst_state",    32'(bus.state_dbg), 32'd0);

    // Nominal lock: PLL_RST high for exactly 4 cycles after release
    RST = 1'b0;
    step(3);
    chk("nom_pll_rst_hi", 32'(bus.PLL_RST), 32'd1);
    step(1);
    chk("nom_pll_rst_lo", 32'(bus.PLL_RST), 32'd0);
    chk("nom_state_wait", 32'(bus.state_dbg), 32'd1);
    step(6);
    bus.LOCK = 1'b1;
    // Release 2 (sync) + 8 (stable) + 1 (registered output) edges later
    step(10);
    chk("nom_sys_rst_pre", 32'(bus.SYS_RST), 32'd1);
    chk("nom_ready_pre",   32'(bus.READY),   32'd0);
    step(1);
    chk("nom_sys_rst_rel", 32'(bus.SYS_RST),   32'd0);
    chk("nom_ready_rel",   32'(bus.READY),     32'd1);
    chk("nom_retry",       32'(bus.RETRY_CNT), 32'd0);
    chk("nom_pll_rst",     32'(bus.PLL_RST),   32'd0);

    // Lock loss in RUN: reset asserted exactly 3 edges after LOCK fall
    bus.LOCK = 1'b0;
    step(2);
    chk("loss_sys_rst_2", 32'(bus.SYS_RST), 32'd0);
    chk("loss_ready_2",   32'(bus.READY),   32'd1);
    step(1);
    note_loss();
    chk("loss_sys_rst_3", 32'(bus.SYS_RST),  32'd1);
    chk("loss_ready_3",   32'(bus.READY),    32'd0);
    chk("loss_pll_rst",   32'(bus.PLL_RST),  32'd1);
    chk("loss_cnt_1",     32'(bus.LOSS_CNT), 32'(loss_exp));
    step(3);
    chk("loss_pulse_hi", 32'(bus.PLL_RST), 32'd1);
    step(1);
    chk("loss_pulse_lo", 32'(bus.PLL_RST), 32'd0);
    bus.LOCK = 1'b1;
    step(10);
    chk("relock_ready_pre", 32'(bus.READY), 32'd0);
    step(1);
    chk("relock_ready", 32'(bus.READY),    32'd1);
    chk("relock_loss",  32'(bus.LOSS_CNT), 32'(loss_exp));

    // RESTART in the same cycle the synchronized lock falls: no loss counted
    bus.LOCK = 1'b0;
    step(2);
    bus.RESTART = 1'b1;
    step(1);
    bus.RESTART = 1'b0;
    chk("rsrun_sys_rst", 32'(bus.SYS_RST),   32'd1);
    chk("rsrun_pll_rst", 32'(bus.PLL_RST),   32'd1);
    chk("rsrun_ready",   32'(bus.READY),     32'd0);
    chk("rsrun_loss",    32'(bus.LOSS_CNT),  32'(loss_exp));
    chk("rsrun_state",   32'(bus.state_dbg), 32'd0);
    step(4);
    chk("rsrun_pll_lo",  32'(bus.PLL_RST), 32'd0);

    // Lock chatter: 5 high, 1 low, then high for good
    bus.LOCK = 1'b1;
    step(5);
    bus.LOCK = 1'b0;
    step(1);
    bus.LOCK = 1'b1;
    step(5);
    chk("chat_ready_nom_pt", 32'(bus.READY), 32'd0);
    step(5);
    chk("chat_ready_pre", 32'(bus.READY), 32'd0);
    step(1);
    chk("chat_ready", 32'(bus.READY),   32'd1);
    chk("chat_sys",   32'(bus.SYS_RST), 32'd0);

    // Timeout / retry / fault
    bus.LOCK = 1'b0;
    step(3);
    note_loss();
    chk("to_sys_rst", 32'(bus.SYS_RST),   32'd1);
    chk("to_loss",    32'(bus.LOSS_CNT),  32'(loss_exp));
    step(4);
    chk("to_win1_start", 32'(bus.PLL_RST), 32'd0);
    step(19);
    chk("to_win1_end_pll",   32'(bus.PLL_RST),   32'd0);
    chk("to_win1_end_retry", 32'(bus.RETRY_CNT), 32'd0);
    step(1);
    chk("to_retry1_pll", 32'(bus.PLL_RST),   32'd1);
    chk("to_retry1_cnt", 32'(bus.RETRY_CNT), 32'd1);
    step(3);
    chk("to_pulse2_hi", 32'(bus.PLL_RST), 32'd1);
    step(1);
    chk("to_pulse2_lo", 32'(bus.PLL_RST), 32'd0);
    step(19);
    chk("to_win2_end_fault", 32'(bus.FAULT), 32'd0);
    step(1);
    chk("fault_flag",  32'(bus.FAULT),     32'd1);
    chk("fault_retry", 32'(bus.RETRY_CNT), 32'd2);
    chk("fault_state", 32'(bus.state_dbg), 32'd4);
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("fault_hold",
          32'({bus.FAULT, bus.PLL_RST, bus.SYS_RST, bus.READY, bus.RETRY_CNT}),
          32'({1'b1, 1'b1, 1'b1, 1'b0, 8'd2}));
    end

    // RESTART out of FAULT
    bus.RESTART = 1'b1;
    step(1);
    bus.RESTART = 1'b0;
    chk("rsf_fault",   32'(bus.FAULT),     32'd0);
    chk("rsf_retry",   32'(bus.RETRY_CNT), 32'd0);
    chk("rsf_pll_rst", 32'(bus.PLL_RST),   32'd1);
    chk("rsf_sys_rst", 32'(bus.SYS_RST),   32'd1);
    step(3);
    chk("rsf_pulse_hi", 32'(bus.PLL_RST), 32'd1);
    step(1);
    chk("rsf_pulse_lo", 32'(bus.PLL_RST), 32'd0);

    // Async reset mid-STABILIZE, asserted for less than a cycle
    bus.LOCK = 1'b1;
    step(5);
    chk("ar_state_stab", 32'(bus.state_dbg), 32'd2);
    #2;
    RST = 1'b1;
    #1;
    chk("ar_pll_rst", 32'(bus.PLL_RST),   32'd1);
    chk("ar_sys_rst", 32'(bus.SYS_RST),   32'd1);
    chk("ar_ready",   32'(bus.READY),     32'd0);
    chk("ar_fault",   32'(bus.FAULT),     32'd0);
    chk("ar_retry",   32'(bus.RETRY_CNT), 32'd0);
    chk("ar_loss",    32'(bus.LOSS_CNT),  32'd0);
    chk("ar_state",   32'(bus.state_dbg), 32'd0);
    #1;
    RST = 1'b0;
    loss_exp = 8'd0;
    step(3);
    chk("ar_pulse_hi", 32'(bus.PLL_RST), 32'd1);
    step(1);
    chk("ar_pulse_lo", 32'(bus.PLL_RST), 32'd0);
    // Synchronizer was cleared too: lock seen 2 edges after release
    step(8);
    chk("ar_ready_pre", 32'(bus.READY), 32'd0);
    step(1);
    chk("ar_ready",    32'(bus.READY),    32'd1);
    chk("ar_loss_end", 32'(bus.LOSS_CNT), 32'(loss_exp));

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
